// File: rtl/zmips_mem_arbiter_if.sv
// Bundle of zmips core-side request ports and the shared external memory bus.
// The arbiter takes the slave view; the core drives the master view, memory the mem view.
interface zmips_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        acc_err;
  logic        stall;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_rd;
  logic        m_wr;
  logic        m_ready;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_rdata, if_ack, d_rdata, d_ack, acc_err, stall
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output if_rdata, if_ack, d_rdata, d_ack, acc_err, stall,
           m_addr, m_wdata, m_rd, m_wr
  );

  modport mem (
    input  m_addr, m_wdata, m_rd, m_wr,
    output m_rdata, m_ready
  );
endinterface

// File: rtl/zmips_mem_arbiter.sv
// Shares one 32-bit memory bus between zmips fetch (IF) and data (D) ports.
// Fixed D priority from IDLE, alternation from RESP, programmable wait states.
module zmips_mem_arbiter #(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                clk,
   input  logic                rst,
   zmips_mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;   // 0 = IF, 1 = D
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic [31:0] if_rdata_q, d_rdata_q;
   logic        cap_if, cap_d;
   logic        grant_if, grant_d;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      cap_if   = 1'b0;
      cap_d    = 1'b0;
      grant_if = 1'b0;
      grant_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.d_req)       grant_d  = 1'b1;
            else if (bus.if_req) grant_if = 1'b1;
         end
         ACC: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else if (bus.m_ready) begin
               state_d = RESP;
               cap_if  = ~we_q & ~owner_q;
               cap_d   = ~we_q &  owner_q;
            end
         end
         RESP: begin
            // The finishing owner is never re-granted here, which yields alternation.
            state_d = IDLE;
            if (owner_q && bus.if_req)      grant_if = 1'b1;
            else if (!owner_q && bus.d_req) grant_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (grant_d) begin
         owner_d = 1'b1;
         addr_d  = bus.d_addr;
         wdata_d = bus.d_wdata;
         we_d    = bus.d_we;
      end else if (grant_if) begin
         owner_d = 1'b0;
         addr_d  = bus.if_addr;
         wdata_d = '0;
         we_d    = 1'b0;
      end

      // Misaligned grants skip the bus and report the error in the ack cycle.
      if (grant_d || grant_if) begin
         cnt_d   = WS;
         err_d   = (addr_d[1:0] != 2'b00);
         state_d = err_d ? RESP : ACC;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(negedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // NOTE: the read-data registers are reset because their post-reset value is visible on the ports.
   always_ff @(negedge clk) begin
      if (rst) begin
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if (cap_if) if_rdata_q <= bus.m_rdata;
         if (cap_d)  d_rdata_q  <= bus.m_rdata;
      end
   end

   assign bus.m_addr   = addr_q;
   assign bus.m_wdata  = wdata_q;
   assign bus.m_rd     = (state_q == ACC) & ~we_q;
   assign bus.m_wr     = (state_q == ACC) &  we_q;
   assign bus.if_ack   = (state_q == RESP) & ~owner_q;
   assign bus.d_ack    = (state_q == RESP) &  owner_q;
   assign bus.acc_err  = (state_q == RESP) &  err_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.stall    = (bus.if_req & ~bus.if_ack) | (bus.d_req & ~bus.d_ack);

endmodule
